// File: rtl/mem_access_unit_if.sv
// Request and RAM handshake bundle for mem_access_unit.
// The slave side is the access unit; the master side is the control unit plus RAM.
interface mem_access_unit_if #(
    parameter int ADDR_W = 9
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              done;
    logic              err;
    logic              busy;
    logic              mem_mov;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_moc;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req, we, size, uns, addr, wdata, mem_moc, mem_rdata,
        output rdata, done, err, busy, mem_mov, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req, we, size, uns, addr, wdata, mem_moc, mem_rdata,
        input  rdata, done, err, busy, mem_mov, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Turns one load/store request into MOV/MOC cycles on a 4-byte-wide big-endian RAM,
// using read-modify-write for byte and halfword stores.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_access_unit_if.slave      bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_d;
    logic              accept_s;
    logic              illegal_s;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [15:0]       wdata_q;
    logic [31:0]       buf_q;
    logic [31:0]       rdata_q;
    logic              done_q;
    logic              err_q;
    logic              busy_q;
    logic              mov_q;
    logic              read_q;
    logic              write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    // Big-endian lane selection: byte offset 0 is the most significant byte.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] wd,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] r;
        r = word;
        if (size == 2'b00) begin
            case (off)
                2'd0:    r[31:24] = wd[7:0];
                2'd1:    r[23:16] = wd[7:0];
                2'd2:    r[15:8]  = wd[7:0];
                default: r[7:0]   = wd[7:0];
            endcase
        end else if (off[1]) begin
            r[15:0] = wd;
        end else begin
            r[31:16] = wd;
        end
        return r;
    endfunction

    assign accept_s  = (state_q == S_IDLE) && bus.req;
    assign illegal_s = (bus.size == 2'b11) ||
                       ((bus.size == 2'b01) && bus.addr[0]) ||
                       ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));

    // Next-state, timeout counter and error decision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.req) begin
                    if (illegal_s) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else if (!bus.we || (bus.size != 2'b10)) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (bus.mem_moc) begin
                    state_d = we_q ? S_MERGE : S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MERGE: begin
                state_d = S_WR;
                cnt_d   = '0;
            end
            S_WR: begin
                if (bus.mem_moc) begin
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, request capture and registered RAM/handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            wdata_q     <= 16'h0000;
            buf_q       <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            mov_q       <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == S_DONE);
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
            // Outputs follow the next state so they switch cleanly on the edge.
            mov_q   <= (state_d == S_RD) || (state_d == S_WR);
            read_q  <= (state_d == S_RD);
            write_q <= (state_d == S_WR);
            if (accept_s) begin
                we_q       <= bus.we;
                uns_q      <= bus.uns;
                size_q     <= bus.size;
                off_q      <= bus.addr[1:0];
                wdata_q    <= bus.wdata[15:0];
                mem_addr_q <= {bus.addr[ADDR_W-1:2], 2'b00};
                if (bus.we && (bus.size == 2'b10)) begin
                    mem_wdata_q <= bus.wdata;
                end
            end
            if ((state_q == S_RD) && bus.mem_moc) begin
                buf_q <= bus.mem_rdata;
                if (!we_q) begin
                    rdata_q <= extract_load(bus.mem_rdata, size_q, off_q, uns_q);
                end
            end
            if (state_q == S_MERGE) begin
                mem_wdata_q <= merge_store(buf_q, wdata_q, size_q, off_q);
            end
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.mem_mov   = mov_q;
    assign bus.mem_read  = read_q;
    assign bus.mem_write = write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
